// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg: shared constants, opcode/state enums and the writes-rd predicate.
// Build option ALU_EXEC_MUL_EN turns opcode B into MUL.
package alu_exec_pkg;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;
    localparam int NUM_REGS = 16;
    localparam logic [ADDR_W-1:0] MAX_REG = ADDR_W'(NUM_REGS);
    typedef enum logic [3:0] {
        OP_ADD = 4'h0, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR,
        OP_ADDI, OP_LI, OP_MOV, OP_CMP, OP_MUL
    } opcode_e;
    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE} state_e;
    function automatic logic op_writes_rd(input logic [3:0] op);
`ifdef ALU_EXEC_MUL_EN
        return (op <= OP_MOV) || (op == OP_MUL);
`else
        return op <= OP_MOV;
`endif
    endfunction
endpackage

// File: rtl/alu_exec_stage_alu_core.sv
// alu_core: combinational ALU with result/flag update enables.
// Build option ALU_EXEC_MUL_EN adds the opcode-B multiplier.
module alu_core
    import alu_exec_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [DATA_W-1:0] i_imm,
    input  logic [3:0]        i_opcode,
    input  logic [2:0]        i_shift,
    output logic [DATA_W-1:0] o_result,
    output logic              o_z,
    output logic              o_c,
    output logic              o_flag_en,
    output logic              o_res_en
);
    logic [DATA_W:0] w_add, w_sub, w_addi, w_shl, w_shr;
    assign w_add  = {1'b0, i_a} + {1'b0, i_b};
    assign w_sub  = {1'b0, i_a} - {1'b0, i_b};
    assign w_addi = {1'b0, i_a} + {1'b0, i_imm};
    // Extra bit catches the last bit shifted out; stays 0 for a zero shift.
    assign w_shl  = {1'b0, i_a} << i_shift;
    assign w_shr  = {i_a, 1'b0} >> i_shift;
`ifdef ALU_EXEC_MUL_EN
    logic [2*DATA_W-1:0] w_mul;
    assign w_mul = i_a * i_b;
`endif
    always_comb begin
        o_result  = '0;
        o_c       = 1'b0;
        o_flag_en = 1'b1;
        case (i_opcode)
            OP_ADD:         {o_c, o_result} = w_add;
            OP_SUB, OP_CMP: {o_c, o_result} = w_sub;
            OP_AND:         o_result = i_a & i_b;
            OP_OR:          o_result = i_a | i_b;
            OP_XOR:         o_result = i_a ^ i_b;
            OP_SHL:         {o_c, o_result} = w_shl;
            OP_SHR:         {o_result, o_c} = w_shr;
            OP_ADDI:        {o_c, o_result} = w_addi;
            OP_LI: begin
                o_result  = i_imm;
                o_flag_en = 1'b0;
            end
            OP_MOV: begin
                o_result  = i_a;
                o_flag_en = 1'b0;
            end
`ifdef ALU_EXEC_MUL_EN
            OP_MUL: begin
                o_result = w_mul[DATA_W-1:0];
                o_c      = |w_mul[2*DATA_W-1:DATA_W];
            end
`endif
            default:        o_flag_en = 1'b0;
        endcase
    end
    assign o_z      = o_result == '0;
    assign o_res_en = op_writes_rd(i_opcode);
endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute/writeback stage driving a register file via READ/EXEC/WRITE.
// Build option ALU_EXEC_MUL_EN (in alu_core) enables MUL on opcode B.
module alu_exec_stage
    import alu_exec_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        opcode,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] imm,
    output logic              rf_rw,
    output logic [ADDR_W-1:0] rf_RS,
    output logic [ADDR_W-1:0] rf_RT,
    output logic [ADDR_W-1:0] rf_RD,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_RS_data,
    input  logic [DATA_W-1:0] rf_RT_data,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              flag_z,
    output logic              flag_c
);
    state_e            r_state;
    logic [3:0]        r_op;
    logic [ADDR_W-1:0] r_rs, r_rt, r_rd, r_rf_rd;
    logic [DATA_W-1:0] r_imm, r_wdata, r_result;
    logic              r_valid, r_z, r_c;
    logic [DATA_W-1:0] w_a, w_b, w_result;
    logic              w_z, w_c, w_flag_en, w_res_en, w_wr;
    assign w_a  = (r_rs != '0 && r_rs <= MAX_REG) ? rf_RS_data : '0;
    assign w_b  = (r_rt != '0 && r_rt <= MAX_REG) ? rf_RT_data : '0;
    assign w_wr = w_res_en && r_rd != '0 && r_rd <= MAX_REG;
    alu_core u_alu (
        .i_a       (w_a),
        .i_b       (w_b),
        .i_imm     (r_imm),
        .i_opcode  (r_op),
        .i_shift   (w_b[2:0]),
        .o_result  (w_result),
        .o_z       (w_z),
        .o_c       (w_c),
        .o_flag_en (w_flag_en),
        .o_res_en  (w_res_en)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_rs     <= '0;
            r_rt     <= '0;
            r_rd     <= '0;
            r_imm    <= '0;
            r_rf_rd  <= '0;
            r_wdata  <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
            r_z      <= 1'b0;
            r_c      <= 1'b0;
        end else begin
            r_valid <= r_state == S_EXEC;
            case (r_state)
                S_IDLE: if (instr_valid) begin
                    r_state <= S_READ;
                    r_op    <= opcode;
                    r_rs    <= rs_addr;
                    r_rt    <= rt_addr;
                    r_rd    <= rd_addr;
                    r_imm   <= imm;
                end
                S_READ: r_state <= S_EXEC;
                S_EXEC: begin
                    r_state <= w_wr ? S_WRITE : S_IDLE;
                    if (w_res_en) r_result <= w_result;
                    if (w_flag_en) {r_z, r_c} <= {w_z, w_c};
                    if (w_wr) begin
                        r_rf_rd <= r_rd;
                        r_wdata <= w_result;
                    end
                end
                S_WRITE: r_state <= S_IDLE;
            endcase
        end
    end
    assign instr_ready  = r_state == S_IDLE;
    assign rf_rw        = r_state == S_WRITE && !rst;
    assign rf_RS        = r_rs;
    assign rf_RT        = r_rt;
    assign rf_RD        = r_rf_rd;
    assign rf_wdata     = r_wdata;
    assign result       = r_result;
    assign result_valid = r_valid;
    assign flag_z       = r_z;
    assign flag_c       = r_c;
endmodule
